// File: rtl/dpi_rec_sched.sv
// Six-channel record scheduler: samples rx/tx lane data, k-flags and valids into per-channel
// slots, then serialises them round-robin onto a ready/valid record port. Optional macro: DPI_SCHED_CHG_EN.
module dpi_rec_sched #(
  parameter int LANS  = 4,
  parameter int WIDTH = 32'h0004_4444
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               cap_en,
  input  logic [5:0]                         ch_mask,
  input  logic [LANS*(WIDTH>>16)*8-1:0]      rdat,
  input  logic [LANS*(WIDTH>>16)*8-1:0]      tdat,
  input  logic [LANS*(WIDTH>>16)-1:0]        rdatk,
  input  logic [LANS*(WIDTH>>16)-1:0]        tdatk,
  input  logic [LANS-1:0]                    rdatv,
  input  logic [LANS-1:0]                    tdatv,
  output logic                               rec_valid,
  input  logic                               rec_ready,
  output logic [63:0]                        rec_time,
  output logic [5:0]                         rec_type,
  output logic [127:0]                       rec_data,
  output logic [31:0]                        drop_cnt,
  output logic                               busy
);

  localparam int NCH = 6;

  logic [63:0]  cnt_r;
  logic [5:0]   pend_r;
  logic [127:0] slot_data_r [NCH];
  logic [63:0]  slot_time_r [NCH];
  logic [2:0]   rr_ptr_r;
  logic         rec_valid_r;
  logic [63:0]  rec_time_r;
  logic [5:0]   rec_type_r;
  logic [127:0] rec_data_r;
  logic [31:0]  drop_cnt_r;

  logic [127:0] ch_val_s [NCH];
  logic [5:0]   chg_s;
  logic [5:0]   samp_s;
  logic [5:0]   drop_s;
  logic [5:0]   acc_s;
  logic [5:0]   grant_oh_s;
  logic [2:0]   grant_idx_s;
  logic         found_s;
  logic         can_load_s;
  logic         grant_s;
  logic [2:0]   ndrop_s;
  logic [32:0]  drop_sum_s;
  int           cand_s;

  // Channel values, zero-extended to the record width.
  always_comb begin
    ch_val_s[0] = 128'(rdat);
    ch_val_s[1] = 128'(rdatk);
    ch_val_s[2] = 128'(rdatv);
    ch_val_s[3] = 128'(tdat);
    ch_val_s[4] = 128'(tdatk);
    ch_val_s[5] = 128'(tdatv);
  end

`ifdef DPI_SCHED_CHG_EN
  logic [127:0] last_r [NCH];
  logic [5:0]   seen_r;

  // A channel qualifies on its first sample after reset or when its value moved.
  always_comb begin
    chg_s = 6'h00;
    for (int i = 0; i < NCH; i++) begin
      chg_s[i] = !seen_r[i] || (ch_val_s[i] != last_r[i]);
    end
  end

  // Last-sampled value per channel, updated on every sample including dropped ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      seen_r <= 6'h00;
      for (int i = 0; i < NCH; i++) last_r[i] <= 128'h0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (samp_s[i]) begin
          seen_r[i] <= 1'b1;
          last_r[i] <= ch_val_s[i];
        end else begin
          seen_r[i] <= seen_r[i];
          last_r[i] <= last_r[i];
        end
      end
    end
  end
`else
  assign chg_s = 6'h3F;
`endif

  // Round-robin search over pending slots starting at the pointer.
  always_comb begin
    found_s     = 1'b0;
    grant_idx_s = 3'd0;
    cand_s      = 0;
    for (int k = 0; k < NCH; k++) begin
      cand_s = int'(rr_ptr_r) + k;
      if (cand_s >= NCH) cand_s = cand_s - NCH;
      else               cand_s = cand_s;
      if (!found_s && pend_r[cand_s]) begin
        found_s     = 1'b1;
        grant_idx_s = 3'(cand_s);
      end else begin
        found_s = found_s;
      end
    end
  end

  assign can_load_s = !rec_valid_r || rec_ready;
  assign grant_s    = found_s && can_load_s;
  assign samp_s     = cap_en ? (ch_mask & chg_s) : 6'h00;

  // A sample into a slot that stays pending this cycle is lost; a slot being granted may refill.
  always_comb begin
    grant_oh_s = 6'h00;
    ndrop_s    = 3'd0;
    for (int i = 0; i < NCH; i++) begin
      grant_oh_s[i] = grant_s && (grant_idx_s == 3'(i));
    end
    drop_s = samp_s & pend_r & ~grant_oh_s;
    acc_s  = samp_s & ~drop_s;
    for (int i = 0; i < NCH; i++) begin
      ndrop_s = ndrop_s + {2'b00, drop_s[i]};
    end
    drop_sum_s = {1'b0, drop_cnt_r} + {30'd0, ndrop_s};
  end

  // Free-running cycle stamp and saturating drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r      <= 64'd0;
      drop_cnt_r <= 32'd0;
    end else begin
      cnt_r      <= cnt_r + 64'd1;
      drop_cnt_r <= drop_sum_s[32] ? 32'hFFFF_FFFF : drop_sum_s[31:0];
    end
  end

  // Per-channel pending slots.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_r <= 6'h00;
      for (int i = 0; i < NCH; i++) begin
        slot_data_r[i] <= 128'h0;
        slot_time_r[i] <= 64'd0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (acc_s[i]) begin
          pend_r[i]      <= 1'b1;
          slot_data_r[i] <= ch_val_s[i];
          slot_time_r[i] <= cnt_r;
        end else if (grant_oh_s[i]) begin
          pend_r[i]      <= 1'b0;
          slot_data_r[i] <= slot_data_r[i];
          slot_time_r[i] <= slot_time_r[i];
        end else begin
          pend_r[i]      <= pend_r[i];
          slot_data_r[i] <= slot_data_r[i];
          slot_time_r[i] <= slot_time_r[i];
        end
      end
    end
  end

  // Output record register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      rec_valid_r <= 1'b0;
      rec_time_r  <= 64'd0;
      rec_type_r  <= 6'd0;
      rec_data_r  <= 128'h0;
      rr_ptr_r    <= 3'd0;
    end else if (grant_s) begin
      rec_valid_r <= 1'b1;
      rec_time_r  <= slot_time_r[grant_idx_s];
      rec_type_r  <= {3'b000, grant_idx_s};
      rec_data_r  <= slot_data_r[grant_idx_s];
      rr_ptr_r    <= (grant_idx_s == 3'd5) ? 3'd0 : grant_idx_s + 3'd1;
    end else if (rec_valid_r && rec_ready) begin
      rec_valid_r <= 1'b0;
    end else begin
      rec_valid_r <= rec_valid_r;
    end
  end

  assign rec_valid = rec_valid_r;
  assign rec_time  = rec_time_r;
  assign rec_type  = rec_type_r;
  assign rec_data  = rec_data_r;
  assign drop_cnt  = drop_cnt_r;
  assign busy      = (|pend_r) || rec_valid_r;

endmodule

// File: tb/tb_dpi_rec_sched.sv
// Directed self-checking bench for dpi_rec_sched; inputs change and outputs are sampled on the falling edge.
module tb_dpi_rec_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic         cap_en;
  logic [5:0]   ch_mask;
  logic [127:0] rdat, tdat;
  logic [15:0]  rdatk, tdatk;
  logic [3:0]   rdatv, tdatv;
  logic         rec_valid;
  logic         rec_ready;
  logic [63:0]  rec_time;
  logic [5:0]   rec_type;
  logic [127:0] rec_data;
  logic [31:0]  drop_cnt;
  logic         busy;

  int errors = 0;
  int checks = 0;

  dpi_rec_sched dut (
    .clk(clk), .rst(rst), .cap_en(cap_en), .ch_mask(ch_mask),
    .rdat(rdat), .tdat(tdat), .rdatk(rdatk), .tdatk(tdatk),
    .rdatv(rdatv), .tdatv(tdatv),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_time(rec_time),
    .rec_type(rec_type), .rec_data(rec_data), .drop_cnt(drop_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; cap_en = 1'b0; ch_mask = 6'h00; rec_ready = 1'b0;
    rdat = 128'h0; tdat = 128'h0; rdatk = 16'h0; tdatk = 16'h0; rdatv = 4'h0; tdatv = 4'h0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (rec_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", rec_valid); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++;
    if (drop_cnt !== 32'd0) begin errors++; $display("FAIL reset_drop: got %0h expected 0", drop_cnt); end
    checks++;
    if ({rec_time, rec_type, rec_data} !== 198'd0) begin
      errors++; $display("FAIL reset_fields: got time=%0h type=%0h data=%0h expected 0", rec_time, rec_type, rec_data);
    end
  endtask

  task automatic test_all_channels();
    logic [127:0] exp_d [6];
    do_reset();
    rdat = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210; rdatk = 16'hA5C3; rdatv = 4'h9;
    tdat = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555; tdatk = 16'h5A3C; tdatv = 4'h6;
    exp_d[0] = rdat; exp_d[1] = 128'hA5C3; exp_d[2] = 128'h9;
    exp_d[3] = tdat; exp_d[4] = 128'h5A3C; exp_d[5] = 128'h6;
    cap_en = 1'b1; ch_mask = 6'h3F; rec_ready = 1'b1;
    step();
    cap_en = 1'b0;
    checks++;
    if (rec_valid !== 1'b0) begin errors++; $display("FAIL all_latency: got valid=%0b expected 0 one edge after sample", rec_valid); end
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if ({rec_valid, rec_type, rec_time, rec_data, drop_cnt} !== {1'b1, 6'(i), 64'd0, exp_d[i], 32'd0}) begin
        errors++;
        $display("FAIL all_rec%0d: got v=%0b type=%0d time=%0h data=%0h drop=%0h expected type=%0d time=0 data=%0h drop=0",
                 i, rec_valid, rec_type, rec_time, rec_data, drop_cnt, i, exp_d[i]);
      end
    end
    step();
    checks++;
    if ({rec_valid, busy} !== 2'b00) begin errors++; $display("FAIL all_drain: got valid=%0b busy=%0b expected 0 0", rec_valid, busy); end
  endtask

  task automatic test_stall();
    int nrec;
    do_reset();
    rdatv = 4'hC; cap_en = 1'b1; ch_mask = 6'h04; rec_ready = 1'b0;
    step();
    cap_en = 1'b0;
    step();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({rec_valid, rec_type, rec_time, rec_data} !== {1'b1, 6'd2, 64'd0, 128'hC}) begin
        errors++;
        $display("FAIL stall_hold%0d: got v=%0b type=%0d time=%0h data=%0h expected v=1 type=2 time=0 data=c",
                 i, rec_valid, rec_type, rec_time, rec_data);
      end
      step();
    end
    rec_ready = 1'b1;
    nrec = 0;
    for (int i = 0; i < 3; i++) begin
      if (rec_valid) nrec++;
      step();
    end
    checks++;
    if (nrec !== 1) begin errors++; $display("FAIL stall_once: got %0d transfers expected 1", nrec); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL stall_idle: got busy=%0b expected 0", busy); end
  endtask

  task automatic test_drop();
    do_reset();
    ch_mask = 6'h01; rec_ready = 1'b0; cap_en = 1'b1;
    rdat = 128'hA;
    step();
    rdat = 128'hB;
    step();
    rdat = 128'hC;
    step();
    cap_en = 1'b0;
    checks++;
    if (drop_cnt !== 32'd1) begin errors++; $display("FAIL drop_count: got %0h expected 1", drop_cnt); end
    checks++;
    if ({rec_valid, rec_time, rec_data} !== {1'b1, 64'd0, 128'hA}) begin
      errors++; $display("FAIL drop_head: got v=%0b time=%0h data=%0h expected v=1 time=0 data=a", rec_valid, rec_time, rec_data);
    end
    rec_ready = 1'b1;
    step();
    checks++;
    if ({rec_valid, rec_time, rec_data, drop_cnt} !== {1'b1, 64'd1, 128'hB, 32'd1}) begin
      errors++; $display("FAIL drop_kept: got v=%0b time=%0h data=%0h drop=%0h expected v=1 time=1 data=b drop=1",
                         rec_valid, rec_time, rec_data, drop_cnt);
    end
    step();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL drop_idle: got busy=%0b expected 0", busy); end
  endtask

  task automatic test_round_robin();
    do_reset();
    ch_mask = 6'h04; cap_en = 1'b1; rec_ready = 1'b1;
    step();
    ch_mask = 6'h09;
    step();
    cap_en = 1'b0;
    checks++;
    if ({rec_valid, rec_type, rec_time} !== {1'b1, 6'd2, 64'd0}) begin
      errors++; $display("FAIL rr_first: got v=%0b type=%0d time=%0h expected v=1 type=2 time=0", rec_valid, rec_type, rec_time);
    end
    step();
    checks++;
    if ({rec_valid, rec_type, rec_time} !== {1'b1, 6'd3, 64'd1}) begin
      errors++; $display("FAIL rr_second: got v=%0b type=%0d time=%0h expected v=1 type=3 time=1", rec_valid, rec_type, rec_time);
    end
    step();
    checks++;
    if ({rec_valid, rec_type, rec_time} !== {1'b1, 6'd0, 64'd1}) begin
      errors++; $display("FAIL rr_third: got v=%0b type=%0d time=%0h expected v=1 type=0 time=1", rec_valid, rec_type, rec_time);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    ch_mask = 6'h3F; cap_en = 1'b1; rec_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (drop_cnt !== 32'(5 * i)) begin errors++; $display("FAIL b2b_drop%0d: got %0d expected %0d", i, drop_cnt, 5 * i); end
      if (i > 0) begin
        checks++;
        if ({rec_valid, rec_type} !== {1'b1, 6'(i - 1)}) begin
          errors++; $display("FAIL b2b_type%0d: got v=%0b type=%0d expected v=1 type=%0d", i, rec_valid, rec_type, i - 1);
        end
      end
    end
    force dut.drop_cnt_r = 32'hFFFF_FFF8;
    #1;
    release dut.drop_cnt_r;
    step();
    checks++;
    if (drop_cnt !== 32'hFFFF_FFFD) begin errors++; $display("FAIL sat_near: got %0h expected fffffffd", drop_cnt); end
    step();
    checks++;
    if (drop_cnt !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_hit: got %0h expected ffffffff", drop_cnt); end
    step();
    checks++;
    if (drop_cnt !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_hold: got %0h expected ffffffff", drop_cnt); end
    cap_en = 1'b0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    ch_mask = 6'h01; cap_en = 1'b1; rec_ready = 1'b0; rdat = 128'h77;
    step();
    cap_en = 1'b0;
    step();
    checks++;
    if (rec_valid !== 1'b1) begin errors++; $display("FAIL mrst_pre: got valid=%0b expected 1", rec_valid); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({rec_valid, busy, drop_cnt} !== {1'b0, 1'b0, 32'd0}) begin
      errors++; $display("FAIL mrst_clear: got v=%0b busy=%0b drop=%0h expected 0 0 0", rec_valid, busy, drop_cnt);
    end
    step();
    step();
    step();
    rdat = 128'hD00D; cap_en = 1'b1;
    step();
    cap_en = 1'b0;
    step();
    checks++;
    if ({rec_valid, rec_time, rec_data} !== {1'b1, 64'd3, 128'hD00D}) begin
      errors++; $display("FAIL mrst_stamp: got v=%0b time=%0h data=%0h expected v=1 time=3 data=d00d", rec_valid, rec_time, rec_data);
    end
  endtask

`ifdef DPI_SCHED_CHG_EN
  task automatic test_change_only();
    int nrec;
    do_reset();
    ch_mask = 6'h04; rec_ready = 1'b1; rdatv = 4'hF; cap_en = 1'b1;
    nrec = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (rec_valid) nrec++;
    end
    cap_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (rec_valid) nrec++;
    end
    checks++;
    if (nrec !== 1) begin errors++; $display("FAIL chg_same: got %0d records expected 1", nrec); end
    rdatv = 4'h3; cap_en = 1'b1;
    step();
    cap_en = 1'b0;
    nrec = 0;
    for (int i = 0; i < 4; i++) begin
      if (rec_valid) begin
        nrec++;
        checks++;
        if (rec_data !== 128'h3) begin errors++; $display("FAIL chg_data: got %0h expected 3", rec_data); end
      end
      step();
    end
    checks++;
    if (nrec !== 1) begin errors++; $display("FAIL chg_new: got %0d records expected 1", nrec); end
  endtask
`endif

  initial begin
    test_reset();
    test_all_channels();
    test_stall();
    test_drop();
    test_round_robin();
    test_back_to_back();
    test_mid_reset();
`ifdef DPI_SCHED_CHG_EN
    test_change_only();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
